// File: rtl/fifo_ctrl.sv
// Control unit for the 2^AW-entry register-file FIFO: pointers, occupancy, write/read decode, status and handshake.
// Optional feature: define FIFO_CTRL_SIMUL_RW_EN to allow a read and a write in the same cycle.
module fifo_ctrl #(
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          wr_en,
    input  logic          rd_en,
    output logic          we,
    output logic [AW-1:0] wr_addr,
    output logic          re,
    output logic [AW-1:0] rd_addr,
    output logic [AW:0]   data_count,
    output logic          full,
    output logic          empty,
    output logic          wr_ack,
    output logic          wr_err,
    output logic          rd_ack,
    output logic          rd_err
);

    typedef enum logic [2:0] {
        ST_INIT     = 3'd0,
        ST_NO_OP    = 3'd1,
        ST_WRITE    = 3'd2,
        ST_WR_ERROR = 3'd3,
        ST_READ     = 3'd4,
        ST_RD_ERROR = 3'd5
    } state_e;

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    state_e        state_q, state_d;
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [AW:0]   count_q, count_d;
    // Side flags carry the read-half result of a simultaneous request, whose state is WRITE.
    logic          simul_rd_ack_q, simul_rd_ack_d;
    logic          simul_rd_err_q, simul_rd_err_d;

    // Per-cycle operation decision and register-file strobes.
    always_comb begin
        state_d        = ST_NO_OP;
        we             = 1'b0;
        re             = 1'b0;
        simul_rd_ack_d = 1'b0;
        simul_rd_err_d = 1'b0;
        case ({wr_en, rd_en})
            2'b10: begin
                if (!full) begin
                    we      = 1'b1;
                    state_d = ST_WRITE;
                end else begin
                    state_d = ST_WR_ERROR;
                end
            end
            2'b01: begin
                if (!empty) begin
                    re      = 1'b1;
                    state_d = ST_READ;
                end else begin
                    state_d = ST_RD_ERROR;
                end
            end
            2'b11: begin
`ifdef FIFO_CTRL_SIMUL_RW_EN
                // Legal when full: the read frees a slot at the same edge the write fills it.
                we      = 1'b1;
                state_d = ST_WRITE;
                if (!empty) begin
                    re             = 1'b1;
                    simul_rd_ack_d = 1'b1;
                end else begin
                    simul_rd_err_d = 1'b1;
                end
`else
                state_d = ST_NO_OP;
`endif
            end
            default: begin
                state_d = ST_NO_OP;
            end
        endcase
    end

    // Pointer and occupancy next-state; errors leave everything untouched.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (re) begin
            head_d = head_q + AW'(1);
        end else begin
            head_d = head_q;
        end
        if (we) begin
            tail_d = tail_q + AW'(1);
        end else begin
            tail_d = tail_q;
        end
        case ({we, re})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // State, pointer and count registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_INIT;
            head_q         <= {AW{1'b0}};
            tail_q         <= {AW{1'b0}};
            count_q        <= {(AW+1){1'b0}};
            simul_rd_ack_q <= 1'b0;
            simul_rd_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            simul_rd_ack_q <= simul_rd_ack_d;
            simul_rd_err_q <= simul_rd_err_d;
        end
    end

    assign wr_addr    = tail_q;
    assign rd_addr    = head_q;
    assign data_count = count_q;
    assign full       = (count_q == DEPTH);
    assign empty      = (count_q == {(AW+1){1'b0}});

    assign wr_ack = (state_q == ST_WRITE);
    assign wr_err = (state_q == ST_WR_ERROR);
    assign rd_ack = (state_q == ST_READ) | simul_rd_ack_q;
    assign rd_err = (state_q == ST_RD_ERROR) | simul_rd_err_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: directed scenarios plus randomized traffic against a queue-based model.
module tb_fifo_ctrl;

    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          wr_en;
    logic          rd_en;
    logic          we;
    logic [AW-1:0] wr_addr;
    logic          re;
    logic [AW-1:0] rd_addr;
    logic [AW:0]   data_count;
    logic          full;
    logic          empty;
    logic          wr_ack;
    logic          wr_err;
    logic          rd_ack;
    logic          rd_err;
    logic [15:0]   dut_status;

    always #5 clk = ~clk;

    fifo_ctrl #(.AW(AW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .we         (we),
        .wr_addr    (wr_addr),
        .re         (re),
        .rd_addr    (rd_addr),
        .data_count (data_count),
        .full       (full),
        .empty      (empty),
        .wr_ack     (wr_ack),
        .wr_err     (wr_err),
        .rd_ack     (rd_ack),
        .rd_err     (rd_err)
    );

    assign dut_status = {wr_ack, wr_err, rd_ack, rd_err, full, empty, data_count, wr_addr, rd_addr};

    int n_checks = 0;
    int n_fail   = 0;

    // Model: queue of addresses of stored entries, running totals of completed writes/reads.
    int m_q[$];
    int m_wcnt;
    int m_rcnt;
    bit m_wack, m_werr, m_rack, m_rerr;
    bit p_we, p_re, p_wack, p_werr, p_rack, p_rerr;

    function automatic logic [15:0] exp_status();
        int sz;
        sz = m_q.size();
        return {m_wack, m_werr, m_rack, m_rerr, (sz == DEPTH), (sz == 0), 4'(sz), 3'(m_wcnt), 3'(m_rcnt)};
    endfunction

    function automatic void model_clear();
        m_q.delete();
        m_wcnt = 0;
        m_rcnt = 0;
        {m_wack, m_werr, m_rack, m_rerr} = 4'b0000;
        {p_we, p_re, p_wack, p_werr, p_rack, p_rerr} = 6'b000000;
    endfunction

    task automatic set_req(input bit w, input bit r);
        int sz;
        wr_en = w;
        rd_en = r;
        #1;
        sz = m_q.size();
        {p_we, p_re, p_wack, p_werr, p_rack, p_rerr} = 6'b000000;
        if (w && !r) begin
            if (sz < DEPTH) begin p_we = 1'b1; p_wack = 1'b1; end
            else p_werr = 1'b1;
        end else if (r && !w) begin
            if (sz > 0) begin p_re = 1'b1; p_rack = 1'b1; end
            else p_rerr = 1'b1;
        end else if (w && r) begin
`ifdef FIFO_CTRL_SIMUL_RW_EN
            p_we   = 1'b1;
            p_wack = 1'b1;
            if (sz > 0) begin p_re = 1'b1; p_rack = 1'b1; end
            else p_rerr = 1'b1;
`endif
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (p_re) begin
            void'(m_q.pop_front());
            m_rcnt++;
        end
        if (p_we) begin
            m_q.push_back(m_wcnt % DEPTH);
            m_wcnt++;
        end
        {m_wack, m_werr, m_rack, m_rerr} = {p_wack, p_werr, p_rack, p_rerr};
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        #2;
        model_clear();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        model_clear();
        #12;
        n_checks++;
        if (dut_status !== 16'h0400) begin n_fail++; $display("FAIL reset_state: got %h want %h", dut_status, 16'h0400); end
        reset_n = 1'b1;
        set_req(1'b0, 1'b0);
        tick();
        n_checks++;
        if (dut_status !== exp_status()) begin n_fail++; $display("FAIL idle_status: got %h want %h", dut_status, exp_status()); end
        set_req(1'b0, 1'b1);
        n_checks++;
        if ({we, re} !== 2'b00) begin n_fail++; $display("FAIL empty_read_strobe: got %b want 00", {we, re}); end
        tick();
        n_checks++;
        if (rd_err !== 1'b1 || rd_ack !== 1'b0 || data_count !== 4'd0) begin
            n_fail++; $display("FAIL empty_read_err: rd_err=%b rd_ack=%b count=%0d want 1 0 0", rd_err, rd_ack, data_count);
        end
        n_checks++;
        if (dut_status !== exp_status()) begin n_fail++; $display("FAIL empty_read_status: got %h want %h", dut_status, exp_status()); end
    endtask

    task automatic test_fill();
        apply_reset();
        for (int i = 0; i < DEPTH; i++) begin
            set_req(1'b1, 1'b0);
            n_checks++;
            if ({we, re, wr_addr} !== {1'b1, 1'b0, 3'(i)}) begin
                n_fail++; $display("FAIL fill_write %0d: we,re,addr got %b want %b", i, {we, re, wr_addr}, {1'b1, 1'b0, 3'(i)});
            end
            tick();
            n_checks++;
            if (dut_status !== exp_status()) begin n_fail++; $display("FAIL fill_status %0d: got %h want %h", i, dut_status, exp_status()); end
        end
        n_checks++;
        if (full !== 1'b1 || data_count !== 4'd8) begin n_fail++; $display("FAIL fill_full: full=%b count=%0d want 1 8", full, data_count); end
        set_req(1'b1, 1'b0);
        n_checks++;
        if (we !== 1'b0) begin n_fail++; $display("FAIL overflow_we: got %b want 0", we); end
        tick();
        n_checks++;
        if (wr_err !== 1'b1 || wr_ack !== 1'b0 || wr_addr !== 3'd0) begin
            n_fail++; $display("FAIL overflow_err: wr_err=%b wr_ack=%b tail=%0d want 1 0 0", wr_err, wr_ack, wr_addr);
        end
        n_checks++;
        if (dut_status !== exp_status()) begin n_fail++; $display("FAIL overflow_status: got %h want %h", dut_status, exp_status()); end
    endtask

    task automatic test_drain();
        for (int i = 0; i < DEPTH; i++) begin
            set_req(1'b0, 1'b1);
            n_checks++;
            if ({we, re, rd_addr} !== {1'b0, 1'b1, 3'(i)} || rd_addr !== 3'(m_q[0])) begin
                n_fail++; $display("FAIL drain_read %0d: we,re,addr got %b want %b", i, {we, re, rd_addr}, {1'b0, 1'b1, 3'(i)});
            end
            tick();
            n_checks++;
            if (dut_status !== exp_status()) begin n_fail++; $display("FAIL drain_status %0d: got %h want %h", i, dut_status, exp_status()); end
        end
        n_checks++;
        if (empty !== 1'b1 || data_count !== 4'd0) begin n_fail++; $display("FAIL drain_empty: empty=%b count=%0d want 1 0", empty, data_count); end
        set_req(1'b0, 1'b1);
        tick();
        n_checks++;
        if (rd_err !== 1'b1 || dut_status !== exp_status()) begin n_fail++; $display("FAIL underflow: got %h want %h", dut_status, exp_status()); end
    endtask

    task automatic test_wrap();
        int exp_seq[6];
        exp_seq = '{5, 6, 7, 0, 1, 2};
        apply_reset();
        for (int i = 0; i < 5; i++) begin set_req(1'b1, 1'b0); tick(); end
        for (int i = 0; i < 5; i++) begin set_req(1'b0, 1'b1); tick(); end
        for (int i = 0; i < 6; i++) begin
            set_req(1'b1, 1'b0);
            n_checks++;
            if (wr_addr !== 3'(exp_seq[i]) || we !== 1'b1) begin
                n_fail++; $display("FAIL wrap_waddr %0d: got %0d want %0d", i, wr_addr, exp_seq[i]);
            end
            tick();
        end
        n_checks++;
        if (data_count !== 4'd6 || dut_status !== exp_status()) begin n_fail++; $display("FAIL wrap_count: got %h want %h", dut_status, exp_status()); end
        for (int i = 0; i < 6; i++) begin
            set_req(1'b0, 1'b1);
            n_checks++;
            if (rd_addr !== 3'(m_q[0]) || rd_addr !== 3'(exp_seq[i])) begin
                n_fail++; $display("FAIL wrap_raddr %0d: got %0d want %0d", i, rd_addr, exp_seq[i]);
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int i = 0; i < 4; i++) begin set_req(1'b1, 1'b0); tick(); end
        set_req(1'b1, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (dut_status !== 16'h0400 || we !== 1'b1) begin
            n_fail++; $display("FAIL async_reset: status got %h want 0400, we got %b want 1", dut_status, we);
        end
        model_clear();
        reset_n = 1'b1;
        set_req(1'b1, 1'b0);
        n_checks++;
        if (wr_addr !== 3'd0 || we !== 1'b1) begin n_fail++; $display("FAIL post_reset_addr: got %0d want 0", wr_addr); end
        tick();
        n_checks++;
        if (dut_status !== exp_status()) begin n_fail++; $display("FAIL post_reset_status: got %h want %h", dut_status, exp_status()); end
    endtask

    task automatic test_simul();
        apply_reset();
        for (int i = 0; i < 3; i++) begin set_req(1'b1, 1'b0); tick(); end
        set_req(1'b1, 1'b1);
        n_checks++;
        if ({we, re} !== {p_we, p_re}) begin n_fail++; $display("FAIL simul_strobe: got %b want %b", {we, re}, {p_we, p_re}); end
        tick();
        n_checks++;
        if (data_count !== 4'd3 || dut_status !== exp_status()) begin
            n_fail++; $display("FAIL simul_count3: got %h want %h", dut_status, exp_status());
        end
        apply_reset();
        set_req(1'b1, 1'b1);
        n_checks++;
        if ({we, re} !== {p_we, p_re}) begin n_fail++; $display("FAIL simul_empty_strobe: got %b want %b", {we, re}, {p_we, p_re}); end
        tick();
        n_checks++;
        if (dut_status !== exp_status()) begin n_fail++; $display("FAIL simul_empty: got %h want %h", dut_status, exp_status()); end
    endtask

    task automatic test_random();
        int wbias;
        int rbias;
        bit w;
        bit r;
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            wbias = ((i / 100) % 2 == 0) ? 70 : 35;
            rbias = ((i / 100) % 2 == 0) ? 35 : 70;
            w = ($urandom_range(0, 99) < wbias);
            r = ($urandom_range(0, 99) < rbias);
            set_req(w, r);
            n_checks++;
            if ({we, re} !== {p_we, p_re}) begin n_fail++; $display("FAIL rand_strobe %0d: got %b want %b", i, {we, re}, {p_we, p_re}); end
            if (p_re) begin
                n_checks++;
                if (rd_addr !== 3'(m_q[0])) begin n_fail++; $display("FAIL rand_order %0d: got %0d want %0d", i, rd_addr, m_q[0]); end
            end
            tick();
            n_checks++;
            if (dut_status !== exp_status()) begin n_fail++; $display("FAIL rand_status %0d: got %h want %h", i, dut_status, exp_status()); end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_async_reset();
        test_simul();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

Control unit for the 8-entry register-file FIFO. Tracks head/tail pointers and occupancy, decides each cycle whether a write, a read, or nothing happens, and drives the write-address/write-enable pair that feeds the register file's 3-to-8 write decoder and the read-address select of the read mux. Also produces the status flags and the per-request acknowledge/error handshake seen by the FIFO user.

## Interface
- AW, 3, pointer/address width; depth = 2^AW (8 entries at default)
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- wr_en  in  1  write request, sampled every rising edge
- rd_en  in  1  read request, sampled every rising edge
- we  out  1  register-file write enable (combinational)
- wr_addr  out  AW  register-file write address = tail (registered pointer)
- re  out  1  output-register load enable for read data (combinational)
- rd_addr  out  AW  register-file read address = head (registered pointer)
- data_count  out  AW+1  occupancy 0..2^AW
- full  out  1  data_count == 2^AW (combinational from count)
- empty  out  1  data_count == 0 (combinational from count)
- wr_ack, wr_err, rd_ack, rd_err  out  1 each  registered handshake result of the previous cycle's request

## Operation
- State register (last operation): INIT, NO_OP, WRITE, WR_ERROR, READ, RD_ERROR. Reset -> INIT.
- Per-cycle decision from (wr_en, rd_en, full, empty):
  - 0,0 -> NO_OP
  - 1,0: !full -> WRITE; full -> WR_ERROR
  - 0,1: !empty -> READ; empty -> RD_ERROR
  - 1,1 -> see Configuration
- we = 1 only in a cycle whose decision is WRITE (or simultaneous R/W); re = 1 only for READ (or simultaneous R/W). Both are 0 in every error and NO_OP decision.
- WRITE: at edge, tail <= tail+1 mod 2^AW, data_count +1.
- READ: at edge, head <= head+1 mod 2^AW, data_count -1.
- Pointers wrap 7 -> 0 silently; full/empty disambiguated only by data_count, never by pointer comparison.
- Handshake outputs decoded from the state register: wr_ack=1 iff state==WRITE, wr_err iff WR_ERROR, rd_ack iff READ, rd_err iff RD_ERROR; at most one of each write pair and read pair high; all 0 in INIT/NO_OP.
- Errors change nothing: pointers, count and register-file contents hold.

## Timing
- Reset (async, any time incl. mid-burst): head=0, tail=0, data_count=0, state=INIT; outputs immediately empty=1, full=0, all ack/err=0, wr_addr=rd_addr=0; we/re follow inputs against empty state.
- Write: request high before edge k -> data captured into entry tail at edge k; wr_ack high during cycle k..k+1 (one-cycle latency); full/data_count updated right after edge k.
- Read: rd_addr=head valid before edge k; datapath loads output register at edge k; rd_ack high in the following cycle, coincident with valid dout.
- Back-to-back requests every cycle supported; throughput 1 op/cycle.
- Requests are not held or retried: an erroring request is dropped and reported once.

## Configuration
- FIFO_CTRL_SIMUL_RW_EN defined: wr_en&rd_en with !empty -> read and write same cycle (we=re=1, both pointers advance, count unchanged, state WRITE with wr_ack=rd_ack=1 via dedicated flag); legal even when full (read frees the slot at the same edge). With empty -> WRITE only, rd_err=1, wr_ack=1.
- Not defined: wr_en&rd_en -> NO_OP, no pointer/count change, all ack/err 0.

## Test plan
- Reset then idle: data_count=0, empty=1, full=0, all ack/err=0; single rd_en -> rd_err=1 next cycle, count stays 0, re=0.
- 8 consecutive writes from empty -> wr_addr 0..7, wr_ack each cycle, data_count 8, full=1; 9th write -> wr_err=1, we=0, tail stays 0.
- 8 reads after fill -> rd_addr 0..7, rd_ack each cycle, data_count 0, empty=1; 9th read -> rd_err=1.
- Wrap: write 5, read 5, write 6 -> wr_addr sequence 5,6,7,0,1,2; data_count 6; reads return entries in order from rd_addr 5.
- Assert reset_n low asynchronously mid-burst at count 4 -> outputs return to reset values without a clock edge; next write lands at address 0.
- wr_en=rd_en=1 at count 3: macro off -> no change, ack/err 0; macro on -> both pointers +1, count 3, wr_ack=rd_ack=1; at count 0 with macro -> count 1, wr_ack=1, rd_err=1.
